// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication, load extraction
// and extension, plus misalignment / illegal-funct3 detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  lane,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_fmt,
  output logic        bad
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unsigned variants exist only for loads.
  always_comb begin
    case (ctrl)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = |lane;
      F3_BU:   bad = write;
      F3_HU:   bad = write | lane[0];
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    if (write) begin
      case (ctrl)
        F3_B: begin
          be         = 4'b0001 << lane;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          be         = 4'b0011 << lane;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ctrl)
      F3_B:    rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata_fmt = {24'h0, byte_sel};
      F3_H:    rdata_fmt = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata_fmt = {16'h0, half_sel};
      default: rdata_fmt = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction at a time, runs a single
// word-aligned RAM access with timeout, and returns a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  ctrl,
  input  logic [31:0] address,
  input  logic [31:0] wData,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rData,
  output logic        fault,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output lsu_state_e  state_dbg
);

  // Handshakes: a request is taken only in IDLE while req_valid=1, and the
  // requester holds req_* while stall=1. A RAM access is offered with
  // mem_valid=1 and mem_* held constant until the cycle mem_ready=1.
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx;
  logic [2:0]  ctrl_q;
  logic        write_q, fault_q, fault_nx;

  logic        idle;
  logic [2:0]  a_ctrl;
  logic [1:0]  a_lane;
  logic        a_write;
  logic [31:0] a_wdata;
  logic [3:0]  be;
  logic [31:0] wlane, rfmt;
  logic        bad;

  assign idle = (state == IDLE);

  // One aligner: checks live inputs while idle, steers the held request after.
  assign a_ctrl  = idle ? ctrl        : ctrl_q;
  assign a_lane  = idle ? address[1:0] : addr_q[1:0];
  assign a_write = idle ? req_write   : write_q;
  assign a_wdata = idle ? wData       : wdata_q;

  lsu_align u_align (
    .ctrl       (a_ctrl),
    .lane       (a_lane),
    .write      (a_write),
    .wdata      (a_wdata),
    .rdata      (mem_rdata),
    .be         (be),
    .wdata_lane (wlane),
    .rdata_fmt  (rfmt),
    .bad        (bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      rdata_q <= rdata_nx;
      fault_q <= fault_nx;
      if (idle && req_valid) begin
        addr_q  <= address;
        wdata_q <= wData;
        ctrl_q  <= ctrl;
        write_q <= req_write;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rdata_nx  = rdata_q;
    fault_nx  = fault_q;
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (req_valid) begin
          if (bad) begin
            state_nx = RESP;
            fault_nx = 1'b1;
            rdata_nx = '0;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        mem_valid = 1'b1;
        mem_write = write_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_be    = be;
        mem_wdata = write_q ? wlane : '0;
        // A completion in the timeout cycle still wins over the fault.
        if (mem_ready) begin
          state_nx = RESP;
          fault_nx = 1'b0;
          rdata_nx = write_q ? '0 : rfmt;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nx = RESP;
          fault_nx = 1'b1;
          rdata_nx = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready  = idle;
  assign stall      = (idle && req_valid) || (state == REQ);
  assign resp_valid = (state == RESP);
  assign fault      = resp_valid && fault_q;
  assign rData      = rdata_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner accesses plus randomized traffic
// checked against a size/lane arithmetic reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  ctrl = '0;
  logic [31:0] address = '0, wData = '0;
  logic        req_ready, stall, resp_valid, fault;
  logic [31:0] rData;
  logic        mem_valid, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  lsu_state_e  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .ctrl(ctrl), .address(address), .wData(wData), .req_ready(req_ready),
    .stall(stall), .resp_valid(resp_valid), .rData(rData), .fault(fault),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference: access size, lane offset and sign rules applied arithmetically.
  function automatic void ref_model(input logic w, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [31:0] rd, output logic bad,
                                    output logic [3:0] be, output logic [31:0] wl,
                                    output logic [31:0] rl);
    int size, a;
    bit sgn, legal;
    logic [31:0] mask, v;
    a = int'(addr[1:0]);
    legal = 1'b1;
    sgn = 1'b1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; sgn = 1'b0; legal = !w; end
      3'd5: begin size = 2; sgn = 1'b0; legal = !w; end
      default: begin size = 4; legal = 1'b0; end
    endcase
    bad = !legal || (a % size != 0);
    be = w ? 4'(((1 << size) - 1) << a) : 4'hF;
    for (int i = 0; i < 4; i++) wl[8*i +: 8] = wd[8*(i % size) +: 8];
    if (size == 4) rl = rd;
    else begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      v = (rd >> (8 * a)) & mask;
      if (sgn && v[8*size-1]) v = v | ~mask;
      rl = v;
    end
  endfunction

  // Driver: presents one request at the current negedge and plays the RAM.
  // lat = REQ cycles before mem_ready (negative or >= TMO: RAM never answers).
  // chained = request presented while the unit is in its RESP cycle.
  task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int lat, input bit chained);
    logic bad, to;
    logic [3:0] be;
    logic [31:0] wl, rl;
    logic [32:0] exp;
    int resp_at, n_req, cyc;
    bit done;
    ref_model(w, f3, addr, wd, rd, bad, be, wl, rl);
    to = !bad && (lat < 0 || lat >= TMO);
    if (bad) resp_at = 1;
    else if (to) resp_at = TMO + 1;
    else resp_at = lat + 2;
    if (chained) resp_at++;
    exp_q.push_back({bad | to, (bad | to | w) ? 32'h0 : rl});
    req_valid = 1'b1; req_write = w; ctrl = f3; address = addr; wData = wd;
    mem_ready = 1'b0;
    #1;
    check("accept_stall", 33'(stall), 33'(!chained));
    check("accept_ready", 33'(req_ready), 33'(!chained));
    n_req = 0; done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (resp_valid) begin
        done = 1'b1;
        exp = exp_q.pop_front();
        check("resp_fault_data", {fault, rData}, exp);
        check("resp_cycle", 33'(cyc), 33'(resp_at));
        check("resp_stall", 33'(stall), 33'(0));
        check("resp_memv", 33'(mem_valid), 33'(0));
        check("req_cycles", 33'(n_req), 33'(bad ? 0 : (to ? TMO : lat + 1)));
        req_valid = 1'b0;
      end else begin
        check("busy_stall", 33'(stall), 33'(1));
        if (mem_valid) begin
          n_req++;
          check("mem_addr", 33'(mem_addr), 33'({addr[31:2], 2'b00}));
          check("mem_be", 33'(mem_be), 33'(be));
          check("mem_write", 33'(mem_write), 33'(w));
          if (w) check("mem_wdata", 33'(mem_wdata), 33'(wl));
          if (n_req == lat + 1) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
          end
        end
      end
    end
    if (!done) check("resp_timeout", 33'(0), 33'(1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_memv"}, 33'(mem_valid), 33'(0));
    check({tag, "_memw"}, 33'(mem_write), 33'(0));
    check({tag, "_be"}, 33'(mem_be), 33'(0));
    check({tag, "_addr"}, 33'(mem_addr), 33'(0));
    check({tag, "_wdata"}, 33'(mem_wdata), 33'(0));
    check({tag, "_resp"}, 33'(resp_valid), 33'(0));
    check({tag, "_fault"}, 33'(fault), 33'(0));
    check({tag, "_rdata"}, 33'(rData), 33'(0));
    check({tag, "_stall"}, 33'(stall), 33'(0));
    check({tag, "_ready"}, 33'(req_ready), 33'(1));
  endtask

  initial begin
    logic w;
    logic [2:0] f3;
    int lat, r;
    bit ch;

    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // LB sign extension from top lane
    do_access(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_FF00, 0, 1'b0);
    @(negedge clk);
    // SH to upper halfword
    do_access(1'b1, F3_H, 32'h202, 32'h1234_ABCD, $urandom, 0, 1'b0);
    @(negedge clk);
    // misaligned LW
    do_access(1'b0, F3_W, 32'h105, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    // LHU timeout
    do_access(1'b0, F3_HU, 32'h10, 32'h0, 32'h0, -1, 1'b0);
    @(negedge clk);
    // SW then LBU back-to-back, 3-cycle RAM
    do_access(1'b1, F3_W, 32'h300, 32'hDEAD_BEEF, $urandom, 2, 1'b0);
    do_access(1'b0, F3_BU, 32'h301, 32'h0, 32'h1234_F678, 2, 1'b1);
    @(negedge clk);
    // mem_ready in the last allowed cycle beats the timeout
    do_access(1'b0, F3_H, 32'h22, 32'h0, 32'h8001_7FFF, TMO - 1, 1'b0);
    @(negedge clk);
    // unsigned store encoding is illegal
    do_access(1'b1, F3_BU, 32'h0, 32'h55, 32'h0, 0, 1'b0);
    @(negedge clk);

    // reset abandons an outstanding access
    req_valid = 1'b1; req_write = 1'b0; ctrl = F3_W; address = 32'h40; wData = '0;
    mem_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_memv", 33'(mem_valid), 33'(1));
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_resp", 33'(resp_valid), 33'(0));
    end

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 7) lat = $urandom_range(0, 4);
      else if (r == 7) lat = TMO - 1;
      else if (r == 8) lat = TMO;
      else lat = -1;
      ch = (n > 0) && ($urandom_range(0, 1) == 1);
      if (!ch) @(negedge clk);
      do_access(w, f3, $urandom, $urandom, $urandom, lat, ch);
    end
    @(negedge clk);
    check("scoreboard_empty", 33'(exp_q.size()), 33'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
